// File: rtl/apb_qch_isolator_if.sv
// rtl/apb_qch_isolator_if.sv - APB request/response bundle for both sides of the Q-channel isolator
interface apb_qch_isolator_if #(
  parameter int AW = 20,
  parameter int DW = 32
);
  logic [AW-1:0]   s_paddr_i;
  logic [2:0]      s_pprot_i;
  logic            s_psel_i;
  logic            s_penable_i;
  logic            s_pwrite_i;
  logic [DW-1:0]   s_pwdata_i;
  logic [DW/8-1:0] s_pstrb_i;
  logic            s_pready_o;
  logic [DW-1:0]   s_prdata_o;
  logic            s_pslverr_o;

  logic [AW-1:0]   m_paddr_o;
  logic [2:0]      m_pprot_o;
  logic            m_psel_o;
  logic            m_penable_o;
  logic            m_pwrite_o;
  logic [DW-1:0]   m_pwdata_o;
  logic [DW/8-1:0] m_pstrb_o;
  logic            m_pready_i;
  logic [DW-1:0]   m_prdata_i;
  logic            m_pslverr_i;

  // Isolator view: upstream request and downstream response come in.
  modport slave (
    input  s_paddr_i, s_pprot_i, s_psel_i, s_penable_i, s_pwrite_i, s_pwdata_i, s_pstrb_i,
    input  m_pready_i, m_prdata_i, m_pslverr_i,
    output s_pready_o, s_prdata_o, s_pslverr_o,
    output m_paddr_o, m_pprot_o, m_psel_o, m_penable_o, m_pwrite_o, m_pwdata_o, m_pstrb_o
  );

  // Environment view: requester plus completer around the isolator.
  modport master (
    output s_paddr_i, s_pprot_i, s_psel_i, s_penable_i, s_pwrite_i, s_pwdata_i, s_pstrb_i,
    output m_pready_i, m_prdata_i, m_pslverr_i,
    input  s_pready_o, s_prdata_o, s_pslverr_o,
    input  m_paddr_o, m_pprot_o, m_psel_o, m_penable_o, m_pwrite_o, m_pwdata_o, m_pstrb_o
  );
endinterface

// File: rtl/apb_qch_isolator.sv
// rtl/apb_qch_isolator.sv - APB4 isolation bridge driven by a Q-channel quiescence handshake
// Clamps the completer side once the bus has been idle long enough; answers upstream locally while clamped.
module apb_qch_isolator #(
  parameter int AW            = 20,
  parameter int DW            = 32,
  parameter int IDLE_CYC      = 4,
  parameter bit DENY_EN       = 1'b1,
  parameter bit ERR_RESP      = 1'b1,
  parameter bit RESET_STOPPED = 1'b1
) (
  input  logic                 pclk_i,
  input  logic                 presetn_i,
  input  logic                 qreqn_i,
  output logic                 qacceptn_o,
  output logic                 qdeny_o,
  output logic                 qactive_o,
  apb_qch_isolator_if.slave    apb
);

  localparam int CW = (IDLE_CYC < 1) ? 1 : $clog2(IDLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_CYC);

  typedef enum logic [2:0] {
    Q_RUN     = 3'd0,
    Q_REQUEST = 3'd1,
    Q_STOPPED = 3'd2,
    Q_EXIT    = 3'd3,
    Q_DENIED  = 3'd4
  } q_state_t;

  q_state_t        r_state;
  logic            r_iso;
  logic            r_qacceptn;
  logic            r_qdeny;
  logic            r_qactive;
  logic [CW-1:0]   r_cnt;
  logic            r_done;

  logic            w_s_pready;
  logic            w_xfer_done;

  assign w_s_pready  = r_iso ? 1'b1 : apb.m_pready_i;
  assign w_xfer_done = apb.s_psel_i & apb.s_penable_i & w_s_pready;

  // r_done marks a transfer that completed after the request arrived, so only later ones deny.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_state    <= RESET_STOPPED ? Q_STOPPED : Q_RUN;
      r_iso      <= RESET_STOPPED;
      r_qacceptn <= ~RESET_STOPPED;
      r_qdeny    <= 1'b0;
      r_qactive  <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_qactive <= apb.s_psel_i;
      unique case (r_state)
        Q_RUN: begin
          if (!qreqn_i) begin
            r_state <= Q_REQUEST;
            r_cnt   <= '0;
            r_done  <= 1'b0;
          end
        end
        Q_REQUEST: begin
          if (qreqn_i) begin
            r_state <= Q_RUN;
          end else if (apb.s_psel_i) begin
            r_cnt <= '0;
            if (w_xfer_done) r_done <= 1'b1;
            if (DENY_EN && ((r_cnt != '0) || r_done)) begin
              r_state <= Q_DENIED;
              r_qdeny <= 1'b1;
            end
          end else if (r_cnt == CNT_MAX) begin
            r_state    <= Q_STOPPED;
            r_iso      <= 1'b1;
            r_qacceptn <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        Q_STOPPED: begin
          if (qreqn_i) r_state <= Q_EXIT;
        end
        Q_EXIT: begin
          // Leave only between transfers or on the access edge of a local one.
          if (!apb.s_psel_i || (apb.s_penable_i && w_s_pready)) begin
            r_state    <= Q_RUN;
            r_iso      <= 1'b0;
            r_qacceptn <= 1'b1;
          end
        end
        Q_DENIED: begin
          if (qreqn_i) begin
            r_state <= Q_RUN;
            r_qdeny <= 1'b0;
          end
        end
        default: begin
          r_state    <= Q_RUN;
          r_iso      <= 1'b0;
          r_qacceptn <= 1'b1;
          r_qdeny    <= 1'b0;
        end
      endcase
    end
  end

  assign qacceptn_o = r_qacceptn;
  assign qdeny_o    = r_qdeny;
  assign qactive_o  = r_qactive;

  assign apb.m_paddr_o   = r_iso ? {AW{1'b0}}   : apb.s_paddr_i;
  assign apb.m_pprot_o   = r_iso ? 3'b000       : apb.s_pprot_i;
  assign apb.m_psel_o    = r_iso ? 1'b0         : apb.s_psel_i;
  assign apb.m_penable_o = r_iso ? 1'b0         : apb.s_penable_i;
  assign apb.m_pwrite_o  = r_iso ? 1'b0         : apb.s_pwrite_i;
  assign apb.m_pwdata_o  = r_iso ? {DW{1'b0}}   : apb.s_pwdata_i;
  assign apb.m_pstrb_o   = r_iso ? {(DW/8){1'b0}} : apb.s_pstrb_i;

  assign apb.s_pready_o  = w_s_pready;
  assign apb.s_prdata_o  = r_iso ? {DW{1'b0}} : apb.m_prdata_i;
  assign apb.s_pslverr_o = r_iso ? ERR_RESP   : apb.m_pslverr_i;

endmodule

// File: tb/tb_apb_qch_isolator.sv
// tb/tb_apb_qch_isolator.sv - scoreboard bench for the APB Q-channel isolator
module tb_apb_qch_isolator;

  logic clk = 1'b0;
  logic presetn = 1'b1;
  logic qreqn = 1'b0;
  logic qacceptn, qdeny, qactive;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } sb_t;
  sb_t sb_q[$];

  logic [31:0] m_rd_val = 32'h1234_5678;

  int          obs_wait;
  logic        obs_m_psel, obs_m_pwrite, obs_qacceptn, obs_qdeny, obs_qactive;
  logic [19:0] obs_m_paddr;
  logic [31:0] obs_m_pwdata;

  apb_qch_isolator_if #(.AW(20), .DW(32)) bus ();

  apb_qch_isolator #(
    .AW(20), .DW(32), .IDLE_CYC(4), .DENY_EN(1'b1), .ERR_RESP(1'b1), .RESET_STOPPED(1'b1)
  ) dut (
    .pclk_i    (clk),
    .presetn_i (presetn),
    .qreqn_i   (qreqn),
    .qacceptn_o(qacceptn),
    .qdeny_o   (qdeny),
    .qactive_o (qactive),
    .apb       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // qreq_sel: -1 leaves qreqn alone, 0/1 drives it together with the setup phase.
  task automatic apb_xfer(input logic wr, input logic [19:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int waits,
                          input int qreq_sel);
    sb_t e;
    bit  got;
    sb_q.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk); #1;
    bus.s_psel_i    = 1'b1;
    bus.s_penable_i = 1'b0;
    bus.s_pwrite_i  = wr;
    bus.s_paddr_i   = addr;
    bus.s_pwdata_i  = wdata;
    bus.s_pstrb_i   = 4'hF;
    bus.s_pprot_i   = 3'b010;
    if (qreq_sel >= 0) qreqn = qreq_sel[0];
    @(posedge clk); #1;
    bus.s_penable_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      bus.m_pready_i = (k >= waits);
      @(negedge clk);
      if (k == 0) begin
        obs_m_psel   = bus.m_psel_o;
        obs_m_pwrite = bus.m_pwrite_o;
        obs_m_paddr  = bus.m_paddr_o;
        obs_m_pwdata = bus.m_pwdata_o;
        obs_qacceptn = qacceptn;
        obs_qdeny    = qdeny;
        obs_qactive  = qactive;
      end
      if (bus.s_pready_o) begin
        got = 1'b1;
        obs_wait = k;
        e = sb_q.pop_front();
        n_tests++;
        if (bus.s_prdata_o !== e.rdata || bus.s_pslverr_o !== e.err) begin
          n_fail++;
          $display("FAIL apb_resp addr=%h: got prdata=%h pslverr=%b, expected prdata=%h pslverr=%b",
                   addr, bus.s_prdata_o, bus.s_pslverr_o, e.rdata, e.err);
        end
      end
    end
    if (!got) begin
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL apb_timeout addr=%h: no pready within 16 cycles, expected prdata=%h", addr, e.rdata);
    end
    @(posedge clk); #1;
    bus.s_psel_i    = 1'b0;
    bus.s_penable_i = 1'b0;
    bus.m_pready_i  = 1'b1;
  endtask

  task automatic test_reset();
    qreqn = 1'b0;
    #1 presetn = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_tests++;
    if (qacceptn !== 1'b0 || qdeny !== 1'b0 || qactive !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_q: got acceptn=%b deny=%b active=%b, expected 0 0 0", qacceptn, qdeny, qactive);
    end
    n_tests++;
    if (bus.m_psel_o !== 1'b0 || bus.m_paddr_o !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_m: got m_psel=%b m_paddr=%h, expected 0 0", bus.m_psel_o, bus.m_paddr_o);
    end
    @(posedge clk); #1 presetn = 1'b1;
    apb_xfer(1'b0, 20'h00010, 32'h0, 32'h0, 1'b1, 0, -1);
    n_tests++;
    if (obs_wait !== 0 || obs_m_psel !== 1'b0) begin
      n_fail++;
      $display("FAIL iso_read: got wait=%0d m_psel=%b, expected 0 0", obs_wait, obs_m_psel);
    end
  endtask

  task automatic do_exit(input string tag);
    @(posedge clk); #1 qreqn = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (qacceptn !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_exit_early: got acceptn=%b, expected 0", tag, qacceptn);
    end
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (qacceptn !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_exit: got acceptn=%b, expected 1", tag, qacceptn);
    end
  endtask

  task automatic test_exit_and_pass();
    do_exit("first");
    apb_xfer(1'b1, 20'h00123, 32'hDEAD_BEEF, m_rd_val, 1'b0, 0, -1);
    n_tests++;
    if (obs_m_pwdata !== 32'hDEAD_BEEF || obs_m_paddr !== 20'h00123 || obs_m_pwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_write: got m_pwdata=%h m_paddr=%h m_pwrite=%b, expected deadbeef 00123 1",
               obs_m_pwdata, obs_m_paddr, obs_m_pwrite);
    end
    apb_xfer(1'b0, 20'h00200, 32'h0, m_rd_val, 1'b0, 1, -1);
  endtask

  task automatic test_entry();
    @(posedge clk); #1;
    qreqn = 1'b0;
    bus.s_paddr_i = 20'hABCDE;
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (qacceptn !== (i < 5)) begin
        n_fail++;
        $display("FAIL entry_lat edge+%0d: got acceptn=%b, expected %b", i, qacceptn, (i < 5));
      end
      if (i == 4) begin
        n_tests++;
        if (bus.m_paddr_o !== 20'hABCDE) begin
          n_fail++;
          $display("FAIL entry_pass: got m_paddr=%h, expected abcde", bus.m_paddr_o);
        end
      end
    end
    n_tests++;
    if (bus.m_paddr_o !== 20'h0 || bus.m_pwdata_o !== 32'h0 || bus.m_pstrb_o !== 4'h0) begin
      n_fail++;
      $display("FAIL entry_clamp: got m_paddr=%h m_pwdata=%h m_pstrb=%h, expected 0",
               bus.m_paddr_o, bus.m_pwdata_o, bus.m_pstrb_o);
    end
  endtask

  task automatic test_deny();
    do_exit("deny");
    @(posedge clk); #1 qreqn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    apb_xfer(1'b0, 20'h00300, 32'h0, m_rd_val, 1'b0, 0, -1);
    n_tests++;
    if (obs_qdeny !== 1'b1 || obs_m_psel !== 1'b1 || obs_qactive !== 1'b1) begin
      n_fail++;
      $display("FAIL deny_set: got deny=%b m_psel=%b active=%b, expected 1 1 1",
               obs_qdeny, obs_m_psel, obs_qactive);
    end
    n_tests++;
    if (qdeny !== 1'b1 || qacceptn !== 1'b1) begin
      n_fail++;
      $display("FAIL deny_hold: got deny=%b acceptn=%b, expected 1 1", qdeny, qacceptn);
    end
    @(posedge clk); #1 qreqn = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (qdeny !== 1'b0) begin
      n_fail++;
      $display("FAIL deny_clear: got deny=%b, expected 0", qdeny);
    end
  endtask

  task automatic test_inflight();
    apb_xfer(1'b0, 20'h00400, 32'h0, m_rd_val, 1'b0, 3, 0);
    n_tests++;
    if (obs_wait !== 3 || obs_m_psel !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_pass: got wait=%0d m_psel=%b, expected 3 1", obs_wait, obs_m_psel);
    end
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (qacceptn !== (i < 5)) begin
        n_fail++;
        $display("FAIL inflight_lat idle+%0d: got acceptn=%b, expected %b", i, qacceptn, (i < 5));
      end
    end
    n_tests++;
    if (qdeny !== 1'b0 || qactive !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_q: got deny=%b active=%b, expected 0 0", qdeny, qactive);
    end
  endtask

  task automatic test_exit_during_access();
    apb_xfer(1'b0, 20'h00040, 32'h0, 32'h0, 1'b1, 0, 1);
    n_tests++;
    if (obs_qacceptn !== 1'b0 || obs_m_psel !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_split: got acceptn=%b m_psel=%b during access, expected 0 0",
               obs_qacceptn, obs_m_psel);
    end
    @(negedge clk);
    n_tests++;
    if (qacceptn !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_after_access: got acceptn=%b, expected 1", qacceptn);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    bus.s_psel_i   = 1'b1;
    bus.s_paddr_i  = 20'h00500;
    bus.s_pwrite_i = 1'b0;
    @(posedge clk); #1;
    bus.s_penable_i = 1'b1;
    bus.m_pready_i  = 1'b0;
    #2;
    n_tests++;
    if (bus.m_psel_o !== 1'b1 || bus.s_pready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_pre: got m_psel=%b pready=%b, expected 1 0", bus.m_psel_o, bus.s_pready_o);
    end
    presetn = 1'b0;
    #1;
    n_tests++;
    if (qacceptn !== 1'b0 || qdeny !== 1'b0 || qactive !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_q: got acceptn=%b deny=%b active=%b, expected 0 0 0", qacceptn, qdeny, qactive);
    end
    n_tests++;
    if (bus.m_psel_o !== 1'b0 || bus.m_penable_o !== 1'b0 || bus.s_pready_o !== 1'b1 ||
        bus.s_prdata_o !== 32'h0 || bus.s_pslverr_o !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_apb: got m_psel=%b m_penable=%b pready=%b prdata=%h pslverr=%b, expected 0 0 1 0 1",
               bus.m_psel_o, bus.m_penable_o, bus.s_pready_o, bus.s_prdata_o, bus.s_pslverr_o);
    end
    bus.s_psel_i    = 1'b0;
    bus.s_penable_i = 1'b0;
    bus.m_pready_i  = 1'b1;
    @(posedge clk); #1 presetn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (qacceptn !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_release: got acceptn=%b, expected 0", qacceptn);
    end
  endtask

  initial begin
    bus.s_paddr_i   = '0;
    bus.s_pprot_i   = '0;
    bus.s_psel_i    = 1'b0;
    bus.s_penable_i = 1'b0;
    bus.s_pwrite_i  = 1'b0;
    bus.s_pwdata_i  = '0;
    bus.s_pstrb_i   = '0;
    bus.m_pready_i  = 1'b1;
    bus.m_prdata_i  = m_rd_val;
    bus.m_pslverr_i = 1'b0;

    test_reset();
    test_exit_and_pass();
    test_entry();
    test_deny();
    test_inflight();
    test_exit_during_access();
    test_async_reset();

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_qch_isolator.md
# apb_qch_isolator

APB4 isolation bridge controlled by a full Q-channel low-power handshake; the parametrised successor of the single-state APB isolator. It sits between an upstream APB requester (s_*) and a power-gateable APB completer (m_*). When quiescence is requested and the bus stays idle for a programmable number of cycles, it clamps the completer side. Otherwise it may deny the request, and while isolated it answers upstream accesses locally.

## Interface
Parameters:
- AW, 20, address width
- DW, 32, data width; multiple of 8
- IDLE_CYC, 4, consecutive idle cycles (s_psel_i=0) required in Q_REQUEST before accepting; 0 is legal
- DENY_EN, 1, 1: a new transfer during the idle count denies the request; 0: the count restarts instead
- ERR_RESP, 1, isolated-access response: 1 gives pslverr=1, 0 gives pslverr=0 (prdata always 0)
- RESET_STOPPED, 1, 1: reset into Q_STOPPED; 0: reset into Q_RUN

Ports:
- pclk_i  in  1  clock
- presetn_i  in  1  reset, asynchronous, active-low
- qreqn_i  in  1  Q-channel request, already synchronous to pclk_i
- qacceptn_o  out  1  Q-channel accept (active low)
- qdeny_o  out  1  Q-channel deny
- qactive_o  out  1  registered s_psel_i (wake hint)
- s_paddr_i / s_pprot_i / s_psel_i / s_penable_i / s_pwrite_i / s_pwdata_i / s_pstrb_i  in  AW/3/1/1/1/DW/DW/8  upstream APB request
- s_pready_o / s_prdata_o / s_pslverr_o  out  1/DW/1  upstream APB response
- m_paddr_o / m_pprot_o / m_psel_o / m_penable_o / m_pwrite_o / m_pwdata_o / m_pstrb_o  out  AW/3/1/1/1/DW/DW/8  downstream APB request
- m_pready_i / m_prdata_i / m_pslverr_i  in  1/DW/1  downstream APB response

## Operation
- States: Q_RUN, Q_REQUEST, Q_STOPPED, Q_EXIT, Q_DENIED. Registered iso flag. Idle counter is $clog2(IDLE_CYC+1) bits wide, minimum 1, and saturates at IDLE_CYC.
- iso=0: all m_* outputs equal their s_* counterparts, and s_pready/s_prdata/s_pslverr equal the m_* responses.
- iso=1: all m_* outputs are 0; s_pready_o=1, s_prdata_o=0, s_pslverr_o=ERR_RESP.
- Q_RUN (iso=0, qacceptn=1, qdeny=0): qreqn_i=0 moves to Q_REQUEST and clears the counter.
- Q_REQUEST (iso=0, qacceptn=1, qdeny=0):
  - s_psel_i=1: counter clears. If counter>0 or a transfer has completed since entry, and DENY_EN=1, the block goes to Q_DENIED. Transfers in flight at entry always finish passthrough.
  - s_psel_i=0 and counter==IDLE_CYC: go to Q_STOPPED; iso becomes 1 and qacceptn becomes 0 on the same edge.
  - s_psel_i=0 otherwise: counter increments.
  - qreqn_i returning to 1 before accept or deny: back to Q_RUN.
- Q_STOPPED (iso=1, qacceptn=0): qreqn_i=1 moves to Q_EXIT.
- Q_EXIT (iso=1, qacceptn=0): when s_psel_i=0, or s_penable_i & s_pready_o, iso becomes 0, qacceptn becomes 1, and the state goes to Q_RUN. An isolated transfer is never split.
- Q_DENIED (iso=0, qdeny=1, qacceptn=1): qreqn_i=1 clears qdeny and returns to Q_RUN.

## Timing
- Reset values:
  - RESET_STOPPED=1: state Q_STOPPED, iso=1, qacceptn_o=0.
  - RESET_STOPPED=0: state Q_RUN, iso=0, qacceptn_o=1.
  - Always: qdeny_o=0, qactive_o=0.
  - All m_* outputs are 0 whenever iso=1.
- Reset is asynchronous at any point, mid-transfer included, and forces the reset state immediately.
- Latency:
  - qreqn_i falling edge sampled at edge N: earliest qacceptn_o=0 is after edge N+1+IDLE_CYC, given an idle bus.
  - qreqn_i rising edge at edge N in Q_STOPPED on an idle bus: qacceptn_o=1 after edge N+1.
- All Q-channel outputs come directly from registers. APB paths are combinational through iso muxes.
- An isolated access completes in 2 cycles (setup plus access, with pready=1).

## Test plan
- Reset with RESET_STOPPED=1 and qreqn_i=0: qacceptn_o=0, m_psel_o=0. A read to 0x00010 returns prdata=0, pslverr=1, pready in the access cycle.
- qreqn_i=1 from Q_STOPPED with an idle bus: qacceptn_o=1 one cycle later. A write of 0xDEADBEEF then reaches m_pwdata_o unchanged.
- Q_RUN, IDLE_CYC=4, qreqn_i=0 on an idle bus: qacceptn_o=0 exactly 5 cycles after the sampling edge, and m_* outputs go to 0.
- DENY_EN=1: a psel pulse 2 cycles into the idle count sets qdeny_o=1 and m_psel_o follows s_psel_i. qreqn_i=1 then clears qdeny_o on the next edge.
- qreqn_i=0 during a transfer with m_pready_i held low for 3 cycles: the transfer completes passthrough and the accept is deferred until IDLE_CYC+1 idle cycles later.
- qreqn_i=1 during an isolated access phase: iso stays 1 until that access completes. Assert presetn_i low mid-transfer: the reset values appear without a clock edge.
